// File: rtl/mul_div_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | mul_div_unit                                                           |
// | Iterative mult/multu/div/divu for the EX stage; owns the HI/LO pair.   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int                 c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_b;
    logic [WIDTH-1:0]     r_orig_a;
    logic                 r_is_div;
    logic                 r_neg;
    logic                 r_rem_neg;
    logic [c_CNT_W-1:0]   r_count;

    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [WIDTH:0]       w_shift;
    logic [WIDTH:0]       w_diff;
    logic [2*WIDTH-1:0]   w_div_next;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_quot;
    logic [WIDTH-1:0]     w_rem;

    // op[0]==0 selects the signed variants (mult, div)
    assign w_a_neg = ~op[0] & dataA[WIDTH-1];
    assign w_b_neg = ~op[0] & dataB[WIDTH-1];
    assign w_abs_a = w_a_neg ? -dataA : dataA;
    assign w_abs_b = w_b_neg ? -dataB : dataB;

    // Multiply: multiplier sits in the low half, shifted out LSB first
    assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
    assign w_mul_next = {w_sum, r_acc[WIDTH-1:1]};

    // Divide: remainder in the high half, dividend/quotient in the low half
    assign w_shift    = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_diff     = w_shift - {1'b0, r_b};
    assign w_div_next = w_diff[WIDTH] ? {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                      : {w_diff[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};

    assign w_prod = r_neg     ? -w_mul_next : w_mul_next;
    assign w_quot = r_neg     ? -w_div_next[WIDTH-1:0] : w_div_next[WIDTH-1:0];
    assign w_rem  = r_rem_neg ? -w_div_next[2*WIDTH-1:WIDTH] : w_div_next[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = (r_state != S_IDLE);
        done         = (r_state == S_DONE);
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   if (r_count == c_LAST) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_b       <= '0;
            r_orig_a  <= '0;
            r_is_div  <= 1'b0;
            r_neg     <= 1'b0;
            r_rem_neg <= 1'b0;
            r_count   <= '0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_is_div  <= op[1];
                        r_neg     <= w_a_neg ^ w_b_neg;
                        r_rem_neg <= w_a_neg;
                        r_orig_a  <= dataA;
                        r_count   <= '0;
                        if (op[1]) begin
                            r_acc <= {{WIDTH{1'b0}}, w_abs_a};
                            r_b   <= w_abs_b;
                        end else begin
                            r_acc <= {{WIDTH{1'b0}}, w_abs_b};
                            r_b   <= w_abs_a;
                        end
                    end else begin
                        if (mthi) hi <= dataA;
                        if (mtlo) lo <= dataA;
                    end
                end
                S_RUN: begin
                    r_acc   <= r_is_div ? w_div_next : w_mul_next;
                    r_count <= r_count + c_CNT_W'(1);
                    if (r_count == c_LAST) begin
                        if (!r_is_div) begin
                            hi <= w_prod[2*WIDTH-1:WIDTH];
                            lo <= w_prod[WIDTH-1:0];
                        end else if (r_b == '0) begin
                            hi <= r_orig_a;
                            lo <= '1;
                        end else begin
                            hi <= w_rem;
                            lo <= w_quot;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_mul_div_unit                                                        |
// | Randomized and directed checks of mul_div_unit against a math model.   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] dataA = '0;
    logic [31:0] dataB = '0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .dataA (dataA),
        .dataB (dataB),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    // Reference result {HI, LO} from plain integer arithmetic
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint          q;
        longint          r;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (o)
            2'b00: res = sa * sb;
            2'b01: res = ua * ub;
            2'b10: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else begin
                    q = longint'(ua / ub);
                    r = longint'(ua % ub);
                    res = {r[31:0], q[31:0]};
                end
            end
        endcase
        return res;
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic with_mtlo, input int inj_at, input logic inj_start,
                          input logic inj_mthi, input string name);
        logic [63:0] exp;
        logic [31:0] prev_hi;
        logic [31:0] prev_lo;
        logic        held_ok;
        logic        busy_ok;
        int          n;
        exp     = model(o, a, b);
        prev_hi = hi;
        prev_lo = lo;
        held_ok = 1'b1;
        busy_ok = 1'b1;
        @(negedge clk);
        start = 1'b1; op = o; dataA = a; dataB = b; mtlo = with_mtlo;
        @(posedge clk); #1;
        start = 1'b0; mtlo = 1'b0;
        n = 1;
        while (!done && n < 40) begin
            if (!busy) busy_ok = 1'b0;
            if (hi !== prev_hi || lo !== prev_lo) held_ok = 1'b0;
            if (n == inj_at) begin
                start = inj_start; mthi = inj_mthi;
                op = 2'b01; dataA = inj_mthi ? 32'h1234_5678 : 32'd2; dataB = 32'd3;
            end else begin
                start = 1'b0; mthi = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0; mthi = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s timeout: done not seen after %0d cycles, required within 33", name, n);
        end
        checks++;
        if (n != 33) begin
            errors++;
            $display("FAIL %s latency: done in cycle %0d, required cycle 33", name, n);
        end
        checks++;
        if (!busy_ok || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy: busy dropped during operation, required high for 33 cycles", name);
        end
        checks++;
        if (!held_ok) begin
            errors++;
            $display("FAIL %s hold: HI/LO changed during RUN, required %h/%h held", name, prev_hi, prev_lo);
        end
        checks++;
        if (hi !== exp[63:32] || lo !== exp[31:0]) begin
            errors++;
            $display("FAIL %s result: op=%0d a=%h b=%h got hi=%h lo=%h, required hi=%h lo=%h",
                     name, o, a, b, hi, lo, exp[63:32], exp[31:0]);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s idle: busy=%b done=%b after completion, required 0/0", name, busy, done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b hi=%h lo=%h, required 0/0/0/0", busy, done, hi, lo);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        run_op(2'b00, 32'd7, 32'hFFFF_FFFD, 1'b0, 0, 1'b0, 1'b0, "mult_7x-3");
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 1'b0, 1'b0, "multu_max");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 0, 1'b0, 1'b0, "div_-7/2");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, 1'b0, 1'b0, "div_overflow");
        run_op(2'b11, 32'd100, 32'd0, 1'b0, 0, 1'b0, 1'b0, "divu_by_zero");
        run_op(2'b10, 32'hFFFF_FF9C, 32'd0, 1'b0, 0, 1'b0, 1'b0, "div_by_zero_neg");
    endtask

    task automatic test_ignored();
        run_op(2'b10, 32'd1000, 32'd7, 1'b0, 5, 1'b1, 1'b0, "start_while_busy");
        run_op(2'b11, 32'd12345, 32'd10, 1'b0, 8, 1'b0, 1'b1, "mthi_while_busy");
        run_op(2'b00, 32'hFFFF_FF00, 32'd9, 1'b1, 0, 1'b0, 1'b0, "start_with_mtlo");
    endtask

    task automatic test_mthi_mtlo();
        logic [31:0] v;
        logic [31:0] prev_lo;
        logic [31:0] prev_hi;
        v = $urandom;
        prev_lo = lo;
        @(negedge clk); mthi = 1'b1; dataA = v;
        @(posedge clk); #1; mthi = 1'b0;
        checks++;
        if (hi !== v || lo !== prev_lo) begin
            errors++;
            $display("FAIL mthi_idle: hi=%h lo=%h, required hi=%h lo=%h", hi, lo, v, prev_lo);
        end
        v = $urandom;
        prev_hi = hi;
        @(negedge clk); mtlo = 1'b1; dataA = v;
        @(posedge clk); #1; mtlo = 1'b0;
        checks++;
        if (lo !== v || hi !== prev_hi) begin
            errors++;
            $display("FAIL mtlo_idle: hi=%h lo=%h, required hi=%h lo=%h", hi, lo, prev_hi, v);
        end
        v = $urandom;
        @(negedge clk); mthi = 1'b1; mtlo = 1'b1; dataA = v;
        @(posedge clk); #1; mthi = 1'b0; mtlo = 1'b0;
        checks++;
        if (hi !== v || lo !== v) begin
            errors++;
            $display("FAIL mthi_mtlo_both: hi=%h lo=%h, required %h/%h", hi, lo, v, v);
        end
    endtask

    task automatic test_reset_mid();
        run_op(2'b01, 32'd5, 32'hABCD_0001, 1'b0, 0, 1'b0, 1'b0, "pre_reset_mult");
        @(negedge clk);
        start = 1'b1; op = 2'b00; dataA = 32'd123; dataB = 32'd456;
        @(posedge clk); #1; start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h, required 0/0/0/0", busy, done, hi, lo);
        end
        @(negedge clk); rst = 1'b0;
        run_op(2'b00, 32'hFFFF_FFF0, 32'h0000_0101, 1'b0, 0, 1'b0, 1'b0, "after_reset_mult");
    endtask

    task automatic test_random();
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 16));
                2: a = 32'h8000_0000;
                3: b = 32'hFFFF_FFFF;
                default: ;
            endcase
            run_op(o, a, b, 1'b0, 0, 1'b0, 1'b0, "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignored();
        test_mthi_mtlo();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
Iterative multiply/divide unit for the EX stage of the pipelined MIPS core. It executes mult, multu, div and divu on the forwarded rs/rt operands and owns the architectural HI and LO registers. It also services mthi/mtlo writes. HI/LO feed the EX result mux for mfhi/mflo, and busy feeds the hazard unit to stall dependent instructions.

Parameters:
WIDTH, 32, operand width in bits; HI and LO are each WIDTH bits; iteration count is WIDTH.

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request a new operation; sampled only in IDLE
op  input  2  00 mult, 01 multu, 10 div, 11 divu; sampled with start
dataA  input  WIDTH  rs operand (multiplicand or dividend)
dataB  input  WIDTH  rt operand (multiplier or divisor)
mthi  input  1  write dataA into HI
mtlo  input  1  write dataA into LO
busy  output  1  high while state != IDLE
done  output  1  one-cycle pulse when the result is committed
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset: clk and rst as named above; reset is synchronous and active-high. At a clock edge with rst=1: state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0, internal operand/accumulator registers=0. Reset overrides everything, including a mid-operation state; a partial result never reaches HI/LO.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1:
  - Latch op.
  - For signed ops (mult, div), latch |dataA| and |dataB| and record the result sign (and, for div, the remainder sign = sign of dataA). Unsigned ops latch the raw values.
  - Latch the original dataA for the divide-by-zero case.
  - counter=0, then go to RUN.
- RUN: one iteration per cycle; counter increments.
  - Multiply: shift-add on a 2*WIDTH-bit product register.
  - Divide: restoring shift-subtract producing a WIDTH-bit quotient and remainder.
  - On the iteration where counter==WIDTH-1, go to DONE. At that same edge, write the sign-corrected result into HI/LO:
    - mult/multu: HI=upper half of the product, LO=lower half.
    - div/divu: LO=quotient, HI=remainder. Negate the quotient if the operand signs differ; the remainder takes the sign of the dividend.
- DONE: done=1 for exactly this one cycle, then go to IDLE.
- Timing: start sampled at edge E0 → busy=1 for WIDTH+1 cycles (33 by default) → done=1 and new HI/LO visible in the final busy cycle → busy=0 in the next cycle. A new start is accepted in the cycle after DONE.
- Divide by zero (dataB=0, div or divu): completes with normal latency; LO=all ones, HI=original dataA.
- Signed overflow (div 0x80000000 / 0xFFFFFFFF): LO=0x80000000, HI=0. This is the natural wrap result.
- start while busy: ignored; no effect on the running operation.
- mthi/mtlo:
  - Honoured only in IDLE, and take effect at the next edge.
  - Both may be asserted together, writing dataA into both registers.
  - If start and mthi/mtlo are asserted together in IDLE, start has priority and mthi/mtlo are ignored.
  - While busy they are ignored; the hazard unit stalls them.
- Outputs hi and lo are direct register outputs with no combinational path from inputs. HI/LO hold their previous values throughout RUN.
- The combined product fits in 2*WIDTH bits with no overflow; all negations are two's complement modulo 2^WIDTH.

Test Plan:
- Signed multiply: op=00 with 7 × 0xFFFFFFFD (−3) → busy high for 33 cycles; done pulses in cycle 33 with HI=0xFFFFFFFF, LO=0xFFFFFFEB; busy=0 in cycle 34.
- Unsigned multiply: op=01 with 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- Signed divide: op=10 with 0xFFFFFFF9 (−7) / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. Also 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- Divide by zero: op=11 with 100 / 0 → LO=0xFFFFFFFF, HI=0x00000064 after 33 cycles.
- Reset mid-operation: start a mult, assert rst for one edge at cycle 10 → next cycle hi=0, lo=0, busy=0, done=0. A new start immediately afterwards completes normally.
- Ignored requests and mthi/mtlo:
  - start (op=01, 2×3) issued at cycle 5 of a running div → ignored; the div result is intact.
  - mthi with dataA=0x12345678 during busy → ignored.
  - mthi/mtlo in IDLE → HI/LO updated next cycle.
  - start together with mtlo → only the operation runs.
